// File: rtl/ecc_dual_port_ram.sv
// Simple-dual-port RAM with SECDED Hamming protection.
// Encodes on write, corrects/detects on read, keeps saturating error counters.
module ecc_dual_port_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  hw_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inj_single,
    input  logic                  inj_double,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  sec_err,
    output logic                  ded_err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [CNT_WIDTH-1:0]  sec_count,
    output logic [CNT_WIDTH-1:0]  ded_count,
    input  logic                  clr_counts
);

    function automatic int calc_p(input int dw);
        int p;
        p = 0;
        for (int k = 7; k >= 1; k--)
            if ((1 << k) >= dw + k + 1) p = k;
        return p;
    endfunction

    localparam int P  = calc_p(DATA_WIDTH);
    localparam int N  = DATA_WIDTH + P;
    localparam int CW = N + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [CW-1:0] c;
        logic          b;
        int            j;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < P; k++) begin
            b = 1'b0;
            for (int pos = 1; pos <= N; pos++)
                if (((pos >> k) & 1) == 1) b = b ^ c[pos-1];
            c[(1<<k)-1] = b;
        end
        c[CW-1] = ^c[N-1:0];
        return c;
    endfunction

    logic [CW-1:0]         mem [DEPTH];
    logic [CW-1:0]         inj_mask;
    logic [CW-1:0]         wr_cw;
    logic [CW-1:0]         rd_q;
    logic                  v1;
    logic [ADDR_WIDTH-1:0] a1;
    logic [ADDR_WIDTH-1:0] out_addr;

    always_comb begin
        inj_mask = '0;
        if (inj_double)      inj_mask[1:0] = 2'b11;
        else if (inj_single) inj_mask[0]   = 1'b1;
        wr_cw = encode(wr_data) ^ inj_mask;
    end

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_cw;
    end

    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            rd_q <= '0;
            v1   <= 1'b0;
            a1   <= '0;
        end else begin
            v1 <= rd_en;
            if (rd_en) begin
                rd_q <= mem[rd_addr];
                a1   <= rd_addr;
            end
        end
    end

    logic [P-1:0]          syn;
    logic                  par;
    logic [CW-1:0]         fixed;
    logic [DATA_WIDTH-1:0] dec_data;
    logic                  dec_sec;
    logic                  dec_ded;

    always_comb begin
        syn = '0;
        for (int pos = 1; pos <= N; pos++)
            if (rd_q[pos-1]) syn = syn ^ P'(pos);
        par     = ^rd_q;
        fixed   = rd_q;
        dec_sec = 1'b0;
        dec_ded = 1'b0;
        if (par) begin
            dec_sec = 1'b1;
            // Syndrome 0 with bad parity: the overall parity bit itself flipped.
            if (syn == '0)
                fixed[CW-1] = ~fixed[CW-1];
            else if (int'(syn) <= N)
                fixed[int'(syn)-1] = ~fixed[int'(syn)-1];
        end else if (syn != '0) begin
            dec_ded = 1'b1;
        end
        dec_data = '0;
        begin
            int j;
            j = 0;
            for (int pos = 1; pos <= N; pos++) begin
                if ((pos & (pos - 1)) != 0) begin
                    dec_data[j] = fixed[pos-1];
                    j++;
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign rd_data  = dec_data;
            assign sec_err  = dec_sec;
            assign ded_err  = dec_ded;
            assign rd_valid = v1;
            assign out_addr = a1;
        end else if (READ_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk or negedge hw_rst) begin
                if (!hw_rst) begin
                    rd_data  <= '0;
                    sec_err  <= 1'b0;
                    ded_err  <= 1'b0;
                    rd_valid <= 1'b0;
                    out_addr <= '0;
                end else begin
                    rd_valid <= v1;
                    if (v1) begin
                        rd_data  <= dec_data;
                        sec_err  <= dec_sec;
                        ded_err  <= dec_ded;
                        out_addr <= a1;
                    end
                end
            end
        end else begin : g_bad
            $error("ecc_dual_port_ram: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            sec_count <= '0;
            ded_count <= '0;
            err_addr  <= '0;
        end else begin
            if (clr_counts) begin
                sec_count <= '0;
                ded_count <= '0;
            end else begin
                if (rd_valid && sec_err && sec_count != '1)
                    sec_count <= sec_count + CNT_WIDTH'(1);
                if (rd_valid && ded_err && ded_count != '1)
                    ded_count <= ded_count + CNT_WIDTH'(1);
            end
            if (rd_valid && (sec_err || ded_err))
                err_addr <= out_addr;
        end
    end

endmodule

// File: tb/tb_ecc_dual_port_ram.sv
// Bench for ecc_dual_port_ram: latency-1 and latency-2 instances on shared
// stimulus, checked every cycle against a word-level memory model.
module tb_ecc_dual_port_ram;

    logic        clk = 1'b0;
    logic        hw_rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        inj_single = 1'b0;
    logic        inj_double = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic        clr_counts = 1'b0;

    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid, a_sec, b_sec, a_ded, b_ded;
    logic [3:0]  a_eaddr, b_eaddr;
    logic [15:0] a_sc, a_dc;
    logic [1:0]  b_sc, b_dc;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    ecc_dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4),
                        .READ_LATENCY(1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .hw_rst(hw_rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .inj_single(inj_single), .inj_double(inj_double),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data), .rd_valid(a_valid),
        .sec_err(a_sec), .ded_err(a_ded), .err_addr(a_eaddr),
        .sec_count(a_sc), .ded_count(a_dc), .clr_counts(clr_counts));

    ecc_dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4),
                        .READ_LATENCY(2), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .hw_rst(hw_rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .inj_single(inj_single), .inj_double(inj_double),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data), .rd_valid(b_valid),
        .sec_err(b_sec), .ded_err(b_ded), .err_addr(b_eaddr),
        .sec_count(b_sc), .ded_count(b_dc), .clr_counts(clr_counts));

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [3:0]  a;
    } ent_t;

    // Model: payload plus injection kind (0 clean, 1 single, 2 double).
    // Injected bits are check bits, so the payload always reads back intact.
    logic [31:0] mdata [16];
    int          mkind [16];
    ent_t        st1 = '0, st2 = '0, h0 = '0, h1 = '0, ne;
    logic [3:0]  ea0 = '0, ea1 = '0;
    logic [15:0] sc0 = '0, dc0 = '0;
    logic [1:0]  sc1 = '0, dc1 = '0;

    always @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            st1 = '0; st2 = '0; h0 = '0; h1 = '0;
            ea0 = '0; ea1 = '0;
            sc0 = '0; dc0 = '0; sc1 = '0; dc1 = '0;
        end else begin
            if (clr_counts) begin
                sc0 = '0; dc0 = '0; sc1 = '0; dc1 = '0;
            end else begin
                if (st1.v && st1.s && sc0 != 16'hffff) sc0++;
                if (st1.v && st1.e && dc0 != 16'hffff) dc0++;
                if (st2.v && st2.s && sc1 != 2'b11) sc1++;
                if (st2.v && st2.e && dc1 != 2'b11) dc1++;
            end
            if (st1.v && (st1.s || st1.e)) ea0 = st1.a;
            if (st2.v && (st2.s || st2.e)) ea1 = st2.a;
            ne.v = rd_en;
            ne.d = mdata[rd_addr];
            ne.s = (mkind[rd_addr] == 1);
            ne.e = (mkind[rd_addr] == 2);
            ne.a = rd_addr;
            if (wr_en) begin
                mdata[wr_addr] = wr_data;
                mkind[wr_addr] = inj_double ? 2 : (inj_single ? 1 : 0);
            end
            st2 = st1;
            st1 = ne;
            if (st1.v) h0 = st1;
            if (st2.v) h1 = st2;
        end
    end

    task automatic cmp(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmp("a_valid", 64'(a_valid), 64'(st1.v));
            cmp("a_data",  64'(a_data),  64'(h0.d));
            cmp("a_sec",   64'(a_sec),   64'(h0.s));
            cmp("a_ded",   64'(a_ded),   64'(h0.e));
            cmp("a_eaddr", 64'(a_eaddr), 64'(ea0));
            cmp("a_sc",    64'(a_sc),    64'(sc0));
            cmp("a_dc",    64'(a_dc),    64'(dc0));
            cmp("b_valid", 64'(b_valid), 64'(st2.v));
            cmp("b_data",  64'(b_data),  64'(h1.d));
            cmp("b_sec",   64'(b_sec),   64'(h1.s));
            cmp("b_ded",   64'(b_ded),   64'(h1.e));
            cmp("b_eaddr", 64'(b_eaddr), 64'(ea1));
            cmp("b_sc",    64'(b_sc),    64'(sc1));
            cmp("b_dc",    64'(b_dc),    64'(dc1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic si, input logic di);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        inj_single = si; inj_double = di;
        tick();
        wr_en = 1'b0; inj_single = 1'b0; inj_double = 1'b0;
    endtask

    initial begin
        #1 hw_rst = 1'b0;
        repeat (3) tick();
        checking = 1;
        cmp("rst_a_data", 64'(a_data), 64'h0);
        cmp("rst_b_valid", 64'(b_valid), 64'h0);
        hw_rst = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) wr(4'(i), $urandom, 1'b0, 1'b0);

        // Clean traffic, back-to-back reads.
        wr(4'd3, 32'hDEADBEEF, 1'b0, 1'b0);
        wr(4'd15, 32'h00000001, 1'b0, 1'b0);
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        cmp("lit_a_d3", 64'(a_data), 64'hDEADBEEF);
        rd_addr = 4'd15;
        tick();
        rd_en = 1'b0;
        cmp("lit_a_d15", 64'(a_data), 64'h1);
        cmp("lit_b_d3", 64'(b_data), 64'hDEADBEEF);
        cmp("lit_b_v", 64'(b_valid), 64'h1);
        tick();
        cmp("lit_b_d15", 64'(b_data), 64'h1);
        cmp("lit_a_sc0", 64'(a_sc), 64'h0);

        // Single-bit injection.
        wr(4'd7, 32'hA5A5A5A5, 1'b1, 1'b0);
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        rd_en = 1'b0;
        cmp("lit_sec_d", 64'(a_data), 64'hA5A5A5A5);
        cmp("lit_sec_f", 64'({a_sec, a_ded}), 64'b10);
        tick();
        cmp("lit_sec_ea", 64'(a_eaddr), 64'd7);
        cmp("lit_sec_cnt", 64'(a_sc), 64'd1);

        // Double-bit injection.
        wr(4'd2, 32'h12345678, 1'b0, 1'b1);
        rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        rd_en = 1'b0;
        cmp("lit_ded_f", 64'({a_sec, a_ded}), 64'b01);
        cmp("lit_ded_d", 64'(a_data), 64'h12345678);
        tick();
        cmp("lit_ded_ea", 64'(a_eaddr), 64'd2);
        cmp("lit_ded_cnt", 64'(a_dc), 64'd1);

        // Read-during-write to the same address.
        wr(4'd5, 32'h11111111, 1'b0, 1'b0);
        rd_en = 1'b1; rd_addr = 4'd5;
        wr(4'd5, 32'h22222222, 1'b0, 1'b0);
        cmp("lit_rdw_old", 64'(a_data), 64'h11111111);
        tick();
        rd_en = 1'b0;
        cmp("lit_rdw_new", 64'(a_data), 64'h22222222);

        // Saturation on the 2-bit counters, then clear against an event.
        wr(4'd9, 32'hCAFEF00D, 1'b1, 1'b0);
        rd_en = 1'b1; rd_addr = 4'd9;
        repeat (5) tick();
        rd_en = 1'b0;
        repeat (3) tick();
        cmp("lit_sat", 64'(b_sc), 64'd3);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        cmp("lit_clr_evt", 64'({b_valid, b_sec}), 64'b11);
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        cmp("lit_clr", 64'(b_sc), 64'd0);

        // Reset with a read in flight.
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        rd_en = 1'b0;
        hw_rst = 1'b0;
        tick();
        cmp("lit_rst_v", 64'(b_valid), 64'h0);
        cmp("lit_rst_d", 64'(b_data), 64'h0);
        hw_rst = 1'b1;
        repeat (2) tick();
        cmp("lit_rst_v2", 64'(b_valid), 64'h0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        cmp("lit_rst_mem", 64'(b_data), 64'hA5A5A5A5);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = 4'($urandom);
            wr_data    = $urandom;
            inj_single = ($urandom_range(0, 7) == 0);
            inj_double = ($urandom_range(0, 9) == 0);
            rd_en      = ($urandom_range(0, 9) < 7);
            rd_addr    = 4'($urandom);
            clr_counts = ($urandom_range(0, 39) == 0);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0; clr_counts = 1'b0;
        inj_single = 1'b0; inj_double = 1'b0;
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
